// File: rtl/cardinal_nic_fifo.sv
// cardinal_nic_fifo -- network interface between one Cardinal processor node
// and its ring router. It has two FIFOs: router->processor (input) and
// processor->router (output). Occupancy is reported in the status registers.
// Injection is gated by the packet's virtual-channel bit.
//
// Data words are big-endian: bit 0 is the MSB and carries the VC bit.
//
// Ports (top):
//   clk            system clock, rising edge
//   reset          synchronous, active-low reset
//   addr[1:0]      register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
//   d_in           processor write data
//   d_out          processor read data (registered)
//   nicEn/nicWrEn  access enable / 1=write 0=read
//   net_si/net_ri  router->NIC send / NIC ready
//   net_di         packet from router
//   net_so/net_ro  NIC->router send / router ready
//   net_do         packet to router (output FIFO head, 0 when empty)
//   net_polarity   router's current polarity

// Circular buffer. The depth must be a power of two, so the pointers wrap for
// free. Full and empty come from the count, because equal pointers are
// ambiguous. A push while full or a pop while empty is ignored.
//   push_i/data_i  write request and data
//   pop_i          pop request
//   head_o         entry at the read pointer, 0 when empty
//   cnt_o          occupancy, log2(DEPTH)+1 bits
//   full_o/empty_o derived from cnt_o
module cardinal_nic_fifo_buf #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [0:DATA_W-1] data_i,
  input  logic              pop_i,
  output logic [0:DATA_W-1] head_o,
  output logic [CW-1:0]     cnt_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [0:DATA_W-1] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // A push and a pop in the same cycle leave the count unchanged.
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset. After a reset the zeroed count makes the old
  // entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

module cardinal_nic_fifo #(
  parameter int DATA_W    = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  localparam int ICW      = $clog2(IN_DEPTH) + 1,
  localparam int OCW      = $clog2(OUT_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam logic [1:0] ADDR_IN_BUF  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF = 2'b10;
  localparam logic [1:0] ADDR_OUT_STA = 2'b11;

  logic [0:DATA_W-1] in_head, out_head;
  logic [ICW-1:0]    in_cnt;
  logic [OCW-1:0]    out_cnt;
  logic              in_full, in_empty, out_full, out_empty;
  logic              proc_rd, in_pop, out_push;
  logic [0:DATA_W-1] d_out_q, d_out_d;

  // Status layout: the flag is in the last (least significant) bit and the
  // 7-bit occupancy sits just above it. All other bits are zero.
  function automatic logic [0:DATA_W-1] status_word(input logic flag,
                                                    input logic [6:0] cnt);
    logic [0:DATA_W-1] w;
    w                     = '0;
    w[DATA_W-8:DATA_W-2]  = cnt;
    w[DATA_W-1]           = flag;
    return w;
  endfunction

  assign proc_rd  = nicEn & ~nicWrEn;
  assign in_pop   = proc_rd & (addr == ADDR_IN_BUF);
  assign out_push = nicEn & nicWrEn & (addr == ADDR_OUT_BUF);

  // net_ri uses the registered count only. Because of that, a pop in this
  // cycle does not open a slot for the router in this cycle.
  assign net_ri = ~in_full;

  // Inject only when the head's VC bit matches the router's polarity. The pop
  // happens in the same cycle, so there is never more than one packet per cycle.
  assign net_so = ~out_empty & net_ro & (out_head[0] == net_polarity);
  assign net_do = out_head;

  cardinal_nic_fifo_buf #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (net_si & net_ri),
    .data_i  (net_di),
    .pop_i   (in_pop),
    .head_o  (in_head),
    .cnt_o   (in_cnt),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  cardinal_nic_fifo_buf #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (out_push),
    .data_i  (d_in),
    .pop_i   (net_so),
    .head_o  (out_head),
    .cnt_o   (out_cnt),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  // Read data is captured from the pre-edge state. A status read therefore
  // ignores any push or pop that lands on the same edge. d_out holds its value
  // between reads.
  always_comb begin
    d_out_d = d_out_q;
    if (proc_rd) begin
      case (addr)
        ADDR_IN_BUF:  d_out_d = in_head;  // already 0 when empty
        ADDR_IN_STAT: d_out_d = status_word(~in_empty, 7'(in_cnt));
        ADDR_OUT_BUF: d_out_d = '0;
        ADDR_OUT_STA: d_out_d = status_word(out_full, 7'(out_cnt));
        default:      d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) d_out_q <= '0;
    else        d_out_q <= d_out_d;
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_cardinal_nic_fifo.sv
module tb_cardinal_nic_fifo;
  localparam int DW = 64;
  localparam int ID = 4;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    addr;
  logic [DW-1:0] d_in, d_out, net_di, net_do;
  logic          nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  cardinal_nic_fifo #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: two packet queues. Data words are numeric, and the VC
  // bit (big-endian bit 0) is bit 63 here.
  logic [DW-1:0] inq[$];
  logic [DW-1:0] outq[$];
  logic          exp_ri, exp_so;
  logic [DW-1:0] exp_do, exp_dout;

  task automatic model_eval();
    exp_ri = (inq.size() < ID);
    exp_so = 1'b0;
    exp_do = '0;
    if (outq.size() > 0) begin
      exp_do = outq[0];
      exp_so = net_ro && (outq[0][63] == net_polarity);
    end
  endtask

  task automatic model_edge();
    bit rd, ipush, ipop, opush, opop;
    if (!reset) begin
      inq.delete();
      outq.delete();
      exp_dout = '0;
      return;
    end
    rd    = nicEn && !nicWrEn;
    ipush = net_si && exp_ri;
    ipop  = rd && addr == 2'd0 && inq.size() > 0;
    opush = nicEn && nicWrEn && addr == 2'd2 && outq.size() < OD;
    opop  = exp_so;
    if (rd) begin
      case (addr)
        2'd0: exp_dout = ipop ? inq[0] : '0;
        2'd1: exp_dout = 64'(inq.size() * 2 + (inq.size() > 0 ? 1 : 0));
        2'd2: exp_dout = '0;
        default: exp_dout = 64'(outq.size() * 2 + (outq.size() == OD ? 1 : 0));
      endcase
    end
    if (ipop)  void'(inq.pop_front());
    if (ipush) inq.push_back(net_di);
    if (opop)  void'(outq.pop_front());
    if (opush) outq.push_back(d_in);
  endtask

  task automatic tick();
    model_eval();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    nicEn = 0; nicWrEn = 0; addr = 2'd0; d_in = '0; net_si = 0; net_di = '0;
  endtask

  function automatic logic [DW-1:0] rnd_word(input bit vc);
    logic [DW-1:0] w;
    w = {$urandom, $urandom};
    w[63] = vc;
    return w;
  endfunction

  task automatic test_reset();
    reset = 0; net_si = 1; net_di = 64'hDEAD; nicEn = 1; nicWrEn = 1;
    addr = 2'd2; d_in = 64'h1234; net_ro = 1; net_polarity = 0;
    repeat (3) tick();
    reset = 1; idle(); #1; model_eval();
    total++; if (net_ri !== 1'b1 || net_ri !== exp_ri) begin bad++; $display("FAIL reset_ri got=%b exp=1", net_ri); end
    total++; if (net_so !== 1'b0) begin bad++; $display("FAIL reset_so got=%b exp=0", net_so); end
    total++; if (net_do !== '0) begin bad++; $display("FAIL reset_do got=%h exp=0", net_do); end
    total++; if (d_out !== '0) begin bad++; $display("FAIL reset_dout got=%h exp=0", d_out); end
    nicEn = 1; addr = 2'd1; tick();
    total++; if (d_out !== '0 || d_out !== exp_dout) begin bad++; $display("FAIL reset_stat_in got=%h exp=0", d_out); end
    addr = 2'd3; tick();
    total++; if (d_out !== '0 || d_out !== exp_dout) begin bad++; $display("FAIL reset_stat_out got=%h exp=0", d_out); end
    idle();
  endtask

  task automatic test_input_fill();
    for (int i = 1; i <= 5; i++) begin
      net_si = 1; net_di = 64'(i); #1; model_eval();
      total++; if (net_ri !== exp_ri) begin bad++; $display("FAIL fill_ri push=%0d got=%b exp=%b", i, net_ri, exp_ri); end
      tick();
    end
    net_si = 0; #1; model_eval();
    total++; if (net_ri !== 1'b0) begin bad++; $display("FAIL fill_full_ri got=%b exp=0", net_ri); end
    nicEn = 1; nicWrEn = 0; addr = 2'd1; tick();
    total++; if (d_out !== 64'h9 || d_out !== exp_dout) begin bad++; $display("FAIL fill_stat got=%h exp=9", d_out); end
    for (int i = 1; i <= 5; i++) begin
      addr = 2'd0; #1; model_eval();
      total++; if (net_ri !== exp_ri) begin bad++; $display("FAIL drain_ri rd=%0d got=%b exp=%b", i, net_ri, exp_ri); end
      tick();
      total++; if (d_out !== (i <= 4 ? 64'(i) : 64'd0) || d_out !== exp_dout) begin bad++; $display("FAIL drain_data rd=%0d got=%h exp=%h", i, d_out, exp_dout); end
    end
    idle();
  endtask

  task automatic test_polarity();
    net_ro = 1; net_polarity = 0;
    nicEn = 1; nicWrEn = 1; addr = 2'd2; d_in = 64'h8000_0000_0000_00AA; tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1; model_eval();
      total++; if (net_so !== 1'b0 || net_so !== exp_so) begin bad++; $display("FAIL pol_hold cyc=%0d got=%b exp=0", i, net_so); end
      total++; if (net_do !== exp_do) begin bad++; $display("FAIL pol_do cyc=%0d got=%h exp=%h", i, net_do, exp_do); end
      tick();
    end
    net_polarity = 1; #1; model_eval();
    total++; if (net_so !== 1'b1 || net_so !== exp_so) begin bad++; $display("FAIL pol_inject got=%b exp=1", net_so); end
    total++; if (net_do !== 64'h8000_0000_0000_00AA) begin bad++; $display("FAIL pol_inject_do got=%h exp=80000000000000aa", net_do); end
    tick(); model_eval();
    total++; if (net_so !== 1'b0) begin bad++; $display("FAIL pol_once got=%b exp=0", net_so); end
    nicEn = 1; nicWrEn = 0; addr = 2'd3; tick();
    total++; if (d_out !== '0 || d_out !== exp_dout) begin bad++; $display("FAIL pol_stat got=%h exp=0", d_out); end
    idle(); net_polarity = 0;
  endtask

  task automatic test_output_full();
    logic [DW-1:0] sent [5];
    net_ro = 0; net_polarity = 0;
    for (int i = 0; i < 5; i++) begin
      sent[i] = rnd_word(1'b0);
      nicEn = 1; nicWrEn = 1; addr = 2'd2; d_in = sent[i]; tick();
    end
    nicWrEn = 0; addr = 2'd3; tick();
    total++; if (d_out !== 64'h9 || d_out !== exp_dout) begin bad++; $display("FAIL full_stat got=%h exp=9", d_out); end
    idle(); net_ro = 1;
    for (int i = 0; i < 4; i++) begin
      #1; model_eval();
      total++; if (net_so !== 1'b1 || net_do !== sent[i]) begin bad++; $display("FAIL full_drain n=%0d so=%b do=%h exp=%h", i, net_so, net_do, sent[i]); end
      tick();
    end
    #1; model_eval();
    total++; if (net_so !== 1'b0 || net_do !== '0) begin bad++; $display("FAIL full_fifth so=%b do=%h exp=0/0", net_so, net_do); end
  endtask

  task automatic test_concurrent_out();
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];
    net_ro = 1; net_polarity = 0;
    for (int i = 0; i < 20; i++) begin
      d_in = rnd_word(1'b0); sent.push_back(d_in);
      nicEn = 1; nicWrEn = 1; addr = 2'd2; #1; model_eval();
      total++; if (net_so !== exp_so || net_do !== exp_do) begin bad++; $display("FAIL conc_out cyc=%0d so=%b do=%h exp=%b/%h", i, net_so, net_do, exp_so, exp_do); end
      if (net_so === 1'b1) got.push_back(net_do);
      tick();
    end
    nicWrEn = 0; addr = 2'd3; #1; model_eval();
    if (net_so === 1'b1) got.push_back(net_do);
    tick();
    total++; if (d_out !== 64'd2 || d_out !== exp_dout) begin bad++; $display("FAIL conc_out_cnt got=%h exp=2", d_out); end
    idle(); #1; model_eval();
    total++; if (net_so !== 1'b0) begin bad++; $display("FAIL conc_out_empty got=%b exp=0", net_so); end
    total++; if (got.size() != 20) begin bad++; $display("FAIL conc_out_len got=%0d exp=20", got.size()); end
    for (int i = 0; i < 20 && i < got.size(); i++) begin
      total++; if (got[i] !== sent[i]) begin bad++; $display("FAIL conc_out_seq n=%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_concurrent_in_reset();
    net_ro = 0;
    for (int i = 0; i < 2; i++) begin
      nicEn = 1; nicWrEn = 1; addr = 2'd2; d_in = rnd_word(1'b0); tick();
    end
    for (int i = 0; i < 16; i++) begin
      reset = (i == 10) ? 1'b0 : 1'b1;
      net_si = 1; net_di = rnd_word($urandom_range(0, 1));
      nicEn = 1; nicWrEn = 0; addr = 2'd0; #1; model_eval();
      total++; if (net_ri !== exp_ri) begin bad++; $display("FAIL conc_in_ri cyc=%0d got=%b exp=%b", i, net_ri, exp_ri); end
      tick();
      total++; if (d_out !== exp_dout) begin bad++; $display("FAIL conc_in_data cyc=%0d got=%h exp=%h", i, d_out, exp_dout); end
      if (i == 10) begin
        total++; if (net_ri !== 1'b1 || net_do !== '0 || d_out !== '0) begin bad++; $display("FAIL mid_reset ri=%b do=%h dout=%h exp=1/0/0", net_ri, net_do, d_out); end
      end
    end
    reset = 1; idle(); nicEn = 1; addr = 2'd1; tick();
    total++; if (d_out !== exp_dout) begin bad++; $display("FAIL conc_in_stat got=%h exp=%h", d_out, exp_dout); end
    addr = 2'd3; tick();
    total++; if (d_out !== '0) begin bad++; $display("FAIL conc_in_ostat got=%h exp=0", d_out); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      net_si = 1'($urandom); net_di = rnd_word(1'($urandom));
      nicEn = ($urandom_range(0, 3) != 0); nicWrEn = 1'($urandom);
      addr = 2'($urandom); d_in = rnd_word(1'($urandom));
      net_ro = ($urandom_range(0, 3) != 0); net_polarity = 1'($urandom);
      #1; model_eval();
      total++; if (net_ri !== exp_ri || net_so !== exp_so || net_do !== exp_do) begin bad++; $display("FAIL rand_hs cyc=%0d ri=%b so=%b do=%h exp=%b/%b/%h", i, net_ri, net_so, net_do, exp_ri, exp_so, exp_do); end
      tick();
      total++; if (d_out !== exp_dout) begin bad++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", i, d_out, exp_dout); end
    end
    idle();
  endtask

  initial begin
    reset = 0; idle(); net_ro = 0; net_polarity = 0;
    test_reset();
    test_input_fill();
    test_polarity();
    test_output_full();
    test_concurrent_out();
    test_concurrent_in_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cardinal_nic_fifo.md
# cardinal_nic_fifo

Parametrised network interface controller between one Cardinal processor node and its ring router in the `cardinal_cmp` chip multiprocessor. It replaces the single-entry NIC buffers with configurable-depth input and output FIFOs, and adds occupancy reporting in the status registers. It also adds virtual-channel (polarity) gated injection, so a node can stream several packets without software handshaking on every word.

## Interface
- DATA_W, 64, packet and processor data width; bit 0 is the MSB (big-endian [0:DATA_W-1] ordering); bit 0 is the packet VC bit.
- IN_DEPTH, 4, input (router→processor) FIFO entries; power of two, 2..64.
- OUT_DEPTH, 4, output (processor→router) FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; asserted when 0.
- addr  in  2  processor register select.
- d_in  in  DATA_W  processor write data.
- d_out  out  DATA_W  processor read data, registered.
- nicEn  in  1  access enable.
- nicWrEn  in  1  1 = write, 0 = read; ignored unless nicEn=1.
- net_si  in  1  router has a packet for this node.
- net_ri  out  1  NIC can accept a packet from the router.
- net_di  in  DATA_W  packet from the router.
- net_so  out  1  NIC is injecting a packet this cycle.
- net_ro  in  1  router can accept an injected packet.
- net_do  out  DATA_W  packet to the router.
- net_polarity  in  1  router's current polarity.

## Operation
Register map:
- 00 = input-channel buffer, read only; a read pops one entry.
- 01 = input status, read only.
- 10 = output-channel buffer, write only; a write pushes one entry.
- 11 = output status, read only.

Status word format:
- bit DATA_W-1 = flag; input flag = non-empty, output flag = full.
- bits [DATA_W-8:DATA_W-2] = occupancy count.
- all other bits = 0.

Router-to-processor path:
- Input FIFO accepts a packet when net_si=1 and net_ri=1.
- net_ri = (input count < IN_DEPTH), computed from the count at the start of the cycle.
- A pop in the same cycle does not raise net_ri.

Processor read of addr 00:
- Non-empty: d_out ← head, then pop.
- Empty: d_out ← 0; no pop and no pointer change.

Processor write of addr 10:
- Not full: push d_in.
- Full: write is dropped; no state change.
- Writes to addr 00, 01 and 11 are ignored.
- Reads of addr 10 return 0.

Injection:
- net_so = 1 when the output FIFO is non-empty, net_ro=1, and head[0] == net_polarity.
- net_do always presents the output FIFO head, or 0 when empty.
- When net_so=1 the head pops in the same cycle.
- At most one packet is injected per cycle.

Simultaneous events:
- A processor push and an injection pop in the same cycle are both honoured; count is unchanged.
- A router push and a processor pop in the same cycle are both honoured.
- Pointers wrap modulo depth.
- Counts are log2(depth)+1 bits wide.
- Full and empty are derived from the counts, never from pointer equality alone.

## Timing
Reset (reset=0 at a rising edge) sets:
- both FIFOs empty and all pointers and counts 0;
- d_out=0, net_so=0, net_do=0, net_ri=1.

Reset behaviour:
- Reset mid-operation discards all buffered packets.
- FIFO contents need not be cleared; they are unreachable after reset.

Processor read latency:
- A read is sampled at edge N; d_out is valid after edge N and holds until the next read or reset.
- A status read at edge N reflects state before any edge-N push or pop.

Output handshakes:
- net_ri and net_so are combinational from registered state plus net_ro and net_polarity.
- They contain no path from net_si or d_in.

Throughput:
- Full throughput of one packet per cycle on each side.
- Router-to-processor: a packet pushed at edge N reads as status non-empty at edge N+1.
- Processor-to-router: a packet written at edge N can inject in the cycle following edge N.

## Test plan
- **Reset state:** hold reset=0 for 3 cycles with net_si=1 and nicEn=1 writing addr 10 → after release, net_ri=1, net_so=0, status 01 reads 0, and status 11 reads 0.
- **Input fill:** IN_DEPTH=4; router pushes 0x..01 to 0x..05 back to back → net_ri=0 after the 4th push and the 5th is not accepted. Status 01 reads count=4, flag=1. Four reads of addr 00 return 01, 02, 03, 04 in order; a 5th read returns 0.
- **Polarity gating:** write packet 0x8000_0000_0000_00AA (VC=1) with net_polarity=0 and net_ro=1 → net_so stays 0. When polarity toggles to 1, net_so=1 for exactly one cycle, net_do=0x8000_0000_0000_00AA, and output status then reads 0.
- **Output full:** OUT_DEPTH=4, net_ro=0; write 5 words → status 11 shows flag=1, count=4. The 5th word is lost; releasing net_ro drains exactly 4 packets in order.
- **Concurrent traffic:** push and pop the output FIFO every cycle for 20 cycles with wrap-around → count is constant, the data sequence is preserved, and there are no duplicates.
- **Concurrent input with mid-stream reset:** router push and processor pop of the input FIFO every cycle → count is constant, the data sequence is preserved, and there are no duplicates. Asserting reset mid-stream empties both FIFOs within one edge.
